uart_tx_periph: RTL

Memory-mapped UART transmitter on the CPU data bus, beside the GPO LED peripheral and the data memory. It decodes its own addresses on the 10-bit data address bus and buffers CPU byte writes in a small FIFO. It serialises each byte as 8N1 on `tx`. The CPU polls a status word through the same read-data mux that selects between boot ROM and data memory.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_tx_periph_if.sv | 11 +
 rtl/uart_tx_periph_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_periph.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// register offsets and status-word bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [9:0] UART_DATA_OFS = 10'd0;
    localparam logic [9:0] UART_STAT_OFS = 10'd4;

    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_EMPTY_BIT  = 1;
    localparam int STAT_ACTIVE_BIT = 2;
    localparam int STAT_OVF_BIT    = 3;
    localparam int STAT_COUNT_LSB  = 4;
    localparam int STAT_COUNT_W    = 5;

    // Builds the status word; every unlisted bit reads as zero.
    function automatic logic [31:0] packStatus(input logic full,
                                               input logic empty,
                                               input logic active,
                                               input logic ovf,
                                               input logic [STAT_COUNT_W-1:0] count);
        logic [31:0] word;
        word = 32'h0;
        word[STAT_FULL_BIT]   = full;
        word[STAT_EMPTY_BIT]  = empty;
        word[STAT_ACTIVE_BIT] = active;
        word[STAT_OVF_BIT]    = ovf;
        word[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        return word;
    endfunction

endpackage

// File: rtl/uart_tx_periph_if.sv
// CPU data-bus slice seen by the UART: byte address, store data/strobe and
// the registered status read-back.
interface uart_tx_periph_if;
    logic [9:0]  address;
    logic [7:0]  data_in;
    logic        write;
    logic [31:0] read_data;

    modport master (output address, output data_in, output write, input read_data);
    modport slave  (input address, input data_in, input write, output read_data);
endinterface

// File: rtl/uart_tx_periph_sync_fifo.sv
// Single-clock FIFO with synchronous reset; a push while full is only
// accepted when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pushEff;
    logic             popEff;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    assign popEff  = pop_i && !empty_o;
    assign pushEff = push_i && (!full_o || popEff);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q + CNT_W'(pushEff) - CNT_W'(popEff);
        if (pushEff) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popEff) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (pushEff) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: address decode, status register,
// byte FIFO, baud counter and serialising FSM with a registered tx line.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter logic [9:0] BASE_ADDR    = 10'h3F0,
    parameter int         CLKS_PER_BIT = 104,
    parameter int         FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_periph_if.slave   bus,
    output logic              tx,
    output logic              busy
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [9:0]        DATA_ADDR = BASE_ADDR + UART_DATA_OFS;
    localparam logic [9:0]        STAT_ADDR = BASE_ADDR + UART_STAT_OFS;

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic [2:0]        nextIdx;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       readData_q;

    logic              wrData;
    logic              wrStat;
    logic              fifoPush;
    logic              fifoPop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;
    logic [7:0]        fifoRdata;

    assign wrData   = bus.write && (bus.address == DATA_ADDR);
    assign wrStat   = bus.write && (bus.address == STAT_ADDR);
    assign fifoPush = wrData && (!fifoFull || fifoPop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .wdata_i (bus.data_in),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign tx            = tx_q;
    assign busy          = !fifoEmpty || (state_q != IDLE);
    assign bus.read_data = readData_q;
    assign nextIdx       = bitIdx_q + 3'd1;

    // A dropped byte is sticky until the status register is written.
    always_comb begin
        overflow_d = overflow_q;
        if (wrStat) begin
            overflow_d = 1'b0;
        end else if (wrData && fifoFull && !fifoPop) begin
            overflow_d = 1'b1;
        end
    end

    // tx_d is the line level for the state being entered, so tx stays registered.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitIdx_d = bitIdx_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        fifoPop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    shreg_d = fifoRdata;
                    baud_d  = BAUD_MAX;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    baud_d   = BAUD_MAX;
                    bitIdx_d = 3'd0;
                    state_d  = DATA;
                    tx_d     = shreg_q[0];
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_MAX;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bitIdx_d = nextIdx;
                        tx_d     = shreg_q[nextIdx];
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_q == '0) begin
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Status is sampled from pre-edge state, giving one cycle of read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bitIdx_q   <= 3'd0;
            shreg_q    <= 8'h00;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            readData_q <= 32'h0000_0002;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bitIdx_q   <= bitIdx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            readData_q <= packStatus(fifoFull, fifoEmpty, state_q != IDLE,
                                     overflow_q, STAT_COUNT_W'(fifoCount));
        end
    end

endmodule
